ram_port_arbiter: RTL and testbench

Shares the single-port data RAM between two requesters: port 0 is the control unit's load/store path and port 1 is the host program/data loader. It is a registered req/gnt arbiter with round-robin fairness and a small FSM that sequences each RAM access. Read data returns to the winning port with a valid pulse. It sits between the requesters and the RAM macro and replaces direct AR/write_ram wiring.

---
 rtl/ram_port_arbiter_pkg.sv | 8 +
 rtl/ram_port_arbiter_if.sv | 11 +
 rtl/ram_port_arbiter_rr_pick2.sv | 13 +
 rtl/ram_port_arbiter.sv | 118 +++++++++++
 tb/tb_ram_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// proc_pkg: shared widths, arbiter state encoding and port indices for ram_port_arbiter.
package proc_pkg;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 16;
    localparam int PORT_CPU   = 0;
    localparam int PORT_HOST  = 1;
    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} arb_state_e;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: two-port requester bus (req/gnt handshake, write data, read-data return).
interface ram_port_arbiter_if import proc_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [1:0]        req, we, gnt, rvalid;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1, rdata;
    modport master (output req, we, addr0, addr1, wdata0, wdata1, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr0, addr1, wdata0, wdata1, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter_rr_pick2.sv
// rr_pick2: two-way winner select; a tie goes to ~last_gnt, or to the host port when fixed_pri is set.
module rr_pick2 import proc_pkg::*; (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       fixed_pri,
    output logic       win,
    output logic       valid
);
    always_comb begin
        valid = |req;
        win   = (&req) ? (fixed_pri ? 1'(PORT_HOST) : ~last_gnt) : req[PORT_HOST];
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares a single-port RAM between the CPU (port 0) and host loader (port 1).
// Define RAM_ARB_FIXED_PRI_EN to make the host win every tie instead of round-robin.
module ram_port_arbiter import proc_pkg::*; #(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RAM_RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_arbiter_if.slave   bus,
    output logic                busy,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);
`ifdef RAM_ARB_FIXED_PRI_EN
    localparam logic FIXED_PRI = 1'b1;
`else
    localparam logic FIXED_PRI = 1'b0;
`endif
    localparam int CNT_W = 2;

    arb_state_e        state_q, state_d;
    logic              last_q, last_d, port_q, port_d;
    logic [1:0]        gnt_q, gnt_d, rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, ram_wdata_q, ram_wdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              win, win_valid;

    rr_pick2 u_pick (
        .req       (bus.req),
        .last_gnt  (last_q),
        .fixed_pri (FIXED_PRI),
        .win       (win),
        .valid     (win_valid)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        port_d      = port_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (win_valid) begin
                state_d     = ACCESS;
                last_d      = win;
                port_d      = win;
                gnt_d       = 2'b01 << win;
                ram_en_d    = 1'b1;
                ram_we_d    = bus.we[win];
                ram_addr_d  = win ? bus.addr1 : bus.addr0;
                ram_wdata_d = win ? bus.wdata1 : bus.wdata0;
            end
            ACCESS: begin
                state_d = ram_we_q ? IDLE : RDWAIT;
                cnt_d   = CNT_W'(RAM_RD_LAT - 1);
            end
            // The counter expires in the cycle the RAM drives the addressed word.
            RDWAIT: if (cnt_q == '0) begin
                state_d  = RESP;
                rdata_d  = ram_rdata;
                rvalid_d = 2'b01 << port_q;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign busy       = state_q != IDLE;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random requests checked each cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
    localparam int AW = 12, DW = 16, LAT = 1, NC = 8192;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
    logic          busy, ram_en, ram_we, busy2, ram_en2, ram_we2;
    logic [AW-1:0] ram_addr, ram_addr2;
    logic [DW-1:0] ram_wdata, ram_rdata, ram_wdata2, ram_rdata2;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));
    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .busy(busy2), .ram_en(ram_en2), .ram_we(ram_we2),
        .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2));

    function automatic logic [DW-1:0] seed_val(input logic [AW-1:0] a);
        return {a[3:0], a} ^ 16'hA5C3;
    endfunction

    // RAM macros: unwritten words read back as seed_val(addr)
    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] mem2 [1<<AW];
    bit            wr_ok [1<<AW];
    bit            wr_ok2 [1<<AW];
    logic [DW-1:0] rd1 = '0, rd2a = '0, rd2b = '0;
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            mem[ram_addr]   <= ram_wdata;
            wr_ok[ram_addr] <= 1'b1;
        end
        if (ram_en && !ram_we) rd1 <= wr_ok[ram_addr] ? mem[ram_addr] : seed_val(ram_addr);
        if (ram_en2 && ram_we2) begin
            mem2[ram_addr2]   <= ram_wdata2;
            wr_ok2[ram_addr2] <= 1'b1;
        end
        if (ram_en2 && !ram_we2) rd2a <= wr_ok2[ram_addr2] ? mem2[ram_addr2] : seed_val(ram_addr2);
        rd2b <= rd2a;
    end
    assign ram_rdata  = rd1;
    assign ram_rdata2 = rd2b;

    int checks = 0, errors = 0, cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] r, input logic l);
`ifdef RAM_ARB_FIXED_PRI_EN
        return r[1] ? 1 : 0;
`else
        return (r == 2'b11) ? (l ? 0 : 1) : (r[1] ? 1 : 0);
`endif
    endfunction

    // Model: each sampling edge either idles or starts one access whose outputs are scheduled ahead
    logic [1:0]    sch_rv [NC];
    logic [DW-1:0] sch_rd [NC];
    logic [DW-1:0] ref_mem [1<<AW];
    bit            ref_ok [1<<AW];
    int            free_at = 0, busy_until = -1, w;
    logic          last = 1'b1;
    logic [1:0]    ex_gnt, ex_rv;
    logic          ex_en, ex_we, ex_busy;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_wdata, ex_rdata;

    initial forever begin
        @(posedge clk);
        cyc++;
        ex_gnt = '0;
        ex_en  = 1'b0;
        ex_we  = 1'b0;
        if (rst) begin
            for (int i = cyc; i < NC; i++) sch_rv[i] = '0;
            last = 1'b1;
            free_at = cyc + 1;
            busy_until = -1;
            ex_addr = '0;
            ex_wdata = '0;
            ex_rdata = '0;
        end else if (cyc >= free_at && bus.req != 2'b00) begin
            w = pick(bus.req, last);
            last = w[0];
            ex_gnt = 2'b01 << w;
            ex_en = 1'b1;
            ex_we = bus.we[w];
            ex_addr = w[0] ? bus.addr1 : bus.addr0;
            ex_wdata = w[0] ? bus.wdata1 : bus.wdata0;
            if (ex_we) begin
                ref_mem[ex_addr] = ex_wdata;
                ref_ok[ex_addr] = 1'b1;
                free_at = cyc + 2;
            end else begin
                sch_rv[cyc+LAT+1] = ex_gnt;
                sch_rd[cyc+LAT+1] = ref_ok[ex_addr] ? ref_mem[ex_addr] : seed_val(ex_addr);
                free_at = cyc + LAT + 3;
            end
            busy_until = free_at - 2;
        end
        ex_rv = sch_rv[cyc];
        if (ex_rv != 2'b00) ex_rdata = sch_rd[cyc];
        ex_busy = cyc <= busy_until;
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("gnt", bus.gnt, ex_gnt);
            check("rvalid", bus.rvalid, ex_rv);
            check("rdata", bus.rdata, ex_rdata);
            check("busy", busy, ex_busy);
            check("ram_en", ram_en, ex_en);
            check("ram_we", ram_we, ex_we);
            check("ram_addr", ram_addr, ex_addr);
            check("ram_wdata", ram_wdata, ex_wdata);
            check("exclusive", {$onehot0(bus.gnt), $onehot0(bus.rvalid), !ram_we || ram_en}, 3'b111);
        end
    end

    task automatic drive(input int d, input int p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (d != 0) begin
            bus2.req[p] = 1'b1;
            bus2.we[p] = wr;
            if (p != 0) begin bus2.addr1 = a; bus2.wdata1 = wd; end
            else begin bus2.addr0 = a; bus2.wdata0 = wd; end
        end else begin
            bus.req[p] = 1'b1;
            bus.we[p] = wr;
            if (p != 0) begin bus.addr1 = a; bus.wdata1 = wd; end
            else begin bus.addr0 = a; bus.wdata0 = wd; end
        end
    endtask

    task automatic wait_pulse(input int d, input bit rv, input int p, output int n);
        logic [1:0] s;
        n = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            n++;
            s = (d != 0) ? (rv ? bus2.rvalid : bus2.gnt) : (rv ? bus.rvalid : bus.gnt);
            if (s[p]) return;
        end
        n = -1;
        checks++;
        errors++;
        $display("FAIL wait_%s dut%0d port %0d: no pulse within 20 cycles", rv ? "rvalid" : "gnt", d, p);
    endtask

    int n, n1, n2;
    logic order [6];

    initial begin
        bus.req = '0; bus.we = '0; bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus2.req = '0; bus2.we = '0; bus2.addr0 = '0; bus2.addr1 = '0; bus2.wdata0 = '0; bus2.wdata1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.gnt, bus.rvalid, bus.rdata, busy, ram_en, ram_we, ram_addr, ram_wdata}, 64'h0);
        // both ports contend from the first cycle after reset
        #1;
        rst = 1'b0;
        drive(0, 0, 1'b1, 12'h001, 16'h1111);
        drive(0, 1, 1'b1, 12'h002, 16'h2222);
        n = 0;
        for (int t = 0; t < 40 && n < 6; t++) begin
            @(posedge clk);
            #1;
            if (bus.gnt != 2'b00) begin
                order[n] = bus.gnt[1];
                n++;
            end
        end
        bus.req = '0;
        check("grant_count", n, 6);
        for (int k = 0; k < 6; k++)
`ifdef RAM_ARB_FIXED_PRI_EN
            check("grant_order", order[k], 1'b1);
`else
            check("grant_order", order[k], k % 2);
`endif
        repeat (3) @(posedge clk);
        #1;
        drive(0, 0, 1'b1, 12'h010, 16'h00AB);
        wait_pulse(0, 1'b0, 0, n);
        check("wr_gnt_latency", n, 1);
        check("wr_ram_strobe", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 12'h010, 16'h00AB});
        bus.req[0] = 1'b0;
        @(posedge clk);
        #1;
        drive(0, 0, 1'b0, 12'h010, 16'h0000);
        wait_pulse(0, 1'b0, 0, n1);
        bus.req[0] = 1'b0;
        wait_pulse(0, 1'b1, 0, n2);
        check("rd_latency", n1 + n2, 3);
        check("rd_data", bus.rdata, 16'h00AB);
        // port 1 arrives while port 0's read is in ACCESS
        @(posedge clk);
        #1;
        drive(0, 0, 1'b0, 12'h020, 16'h0000);
        wait_pulse(0, 1'b0, 0, n1);
        bus.req[0] = 1'b0;
        drive(0, 1, 1'b0, 12'h030, 16'h0000);
        wait_pulse(0, 1'b0, 1, n2);
        check("late_p1_gnt_delay", n2, 4);
        check("late_p1_busy", busy, 1'b1);
        bus.req[1] = 1'b0;
        wait_pulse(0, 1'b1, 1, n);
        check("late_p1_rv_delay", n, 2);
        check("late_p1_rdata", bus.rdata, seed_val(12'h030));
        // reset lands while the read sits in RDWAIT
        @(posedge clk);
        #1;
        drive(0, 0, 1'b0, 12'h040, 16'h0000);
        wait_pulse(0, 1'b0, 0, n);
        bus.req[0] = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_read", {bus.gnt, bus.rvalid, bus.rdata, busy, ram_en, ram_we, ram_addr, ram_wdata}, 64'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk);
            #1;
            check("no_rvalid_after_rst", {bus.rvalid, busy}, 3'b000);
        end
        // two-cycle RAM: host loads 0x1234 at 0xFFF, then reads it back
        drive(1, 1, 1'b1, 12'hFFF, 16'h1234);
        wait_pulse(1, 1'b0, 1, n);
        bus2.req[1] = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 1, 1'b0, 12'hFFF, 16'h0000);
        wait_pulse(1, 1'b0, 1, n1);
        bus2.req[1] = 1'b0;
        wait_pulse(1, 1'b1, 1, n2);
        check("lat2_rd_latency", n1 + n2, 4);
        check("lat2_rd_data", bus2.rdata, 16'h1234);
        // random traffic obeying the requester rules
        for (int t = 0; t < 2000; t++) begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (bus.req[p] && bus.gnt[p]) bus.req[p] = 1'b0;
                else if (!bus.req[p] && $urandom_range(0, 2) == 0)
                    drive(0, p, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15)),
                          16'($urandom));
            end
        end
        bus.req = '0;
        repeat (8) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
